// File: rtl/branch_pkg.sv
// Shared types and encodings for the multicycle control-transfer sequencer.
// Covers FSM states, request kinds, branch conditions and ALU operation select.
package branch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMP  = 3'd1,
        LINK = 3'd2,
        TGT  = 3'd3,
        SEQ  = 3'd4,
        UPD  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        KIND_BRANCH = 2'b00,
        KIND_JAL    = 2'b01,
        KIND_JALR   = 2'b10,
        KIND_RSVD   = 2'b11
    } kind_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic ALU_SEL_ADD = 1'b0;
    localparam logic ALU_SEL_CMP = 1'b1;

    // funct3 010 and 011 have no branch meaning and are treated as illegal.
    function automatic logic branch_legal(input logic [2:0] funct3);
        return (funct3 == F3_BEQ)  || (funct3 == F3_BNE)  ||
               (funct3 == F3_BLT)  || (funct3 == F3_BGE)  ||
               (funct3 == F3_BLTU) || (funct3 == F3_BGEU);
    endfunction

endpackage

// File: rtl/branch_sequencer.sv
// Resolves BRANCH/JAL/JALR by time-sharing the core ALU and comparator over
// several cycles, then updates the PC and the link register.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      kind_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic            alu_sel_o,
    output logic [2:0]      cmp_op_o,
    input  logic [XLEN-1:0] alu_res_i,
    input  logic            cmp_r_i,
    output logic [XLEN-1:0] pc_o,
    output logic            rd_we_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            taken_o,
    output logic            fault_o
);

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    // Current FSM state; visible hierarchically for checkers.
    state_t          state;
    kind_t           kind_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] link_q;
    logic [XLEN-1:0] target_q;
    logic            pc_we_q;
    logic [XLEN-1:0] tgt_sum;

    // Operand mux: the ALU only sees non-zero operands in working states.
    always_comb begin
        alu_a_o   = '0;
        alu_b_o   = '0;
        alu_sel_o = ALU_SEL_ADD;
        cmp_op_o  = 3'b000;
        case (state)
            CMP: begin
                alu_a_o   = rs1_q;
                alu_b_o   = rs2_q;
                alu_sel_o = ALU_SEL_CMP;
                cmp_op_o  = funct3_q;
            end
            LINK, SEQ: begin
                alu_a_o = pc_q;
                alu_b_o = FOUR;
            end
            TGT: begin
                alu_a_o = (kind_q == KIND_JALR) ? rs1_q : pc_q;
                alu_b_o = imm_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        tgt_sum = alu_res_i;
        if (kind_q == KIND_JALR) tgt_sum[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            kind_q    <= KIND_BRANCH;
            funct3_q  <= 3'b000;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            link_q    <= '0;
            target_q  <= '0;
            pc_we_q   <= 1'b0;
            pc_o      <= RESET_PC;
            rd_we_o   <= 1'b0;
            rd_data_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            taken_o   <= 1'b0;
            fault_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        kind_q   <= kind_t'(kind_i);
                        funct3_q <= funct3_i;
                        pc_q     <= pc_i;
                        rs1_q    <= rs1_i;
                        rs2_q    <= rs2_i;
                        imm_q    <= imm_i;
                        busy_o   <= 1'b1;
                        if (kind_i == KIND_JAL || kind_i == KIND_JALR) begin
                            state <= LINK;
                        end else if (kind_i == KIND_BRANCH && branch_legal(funct3_i)) begin
                            state <= CMP;
                        end else begin
                            state   <= UPD;
                            done_o  <= 1'b1;
                            fault_o <= 1'b1;
                            pc_we_q <= 1'b0;
                        end
                    end
                end
                CMP: begin
                    state <= cmp_r_i ? TGT : SEQ;
                end
                LINK: begin
                    link_q <= alu_res_i;
                    state  <= TGT;
                end
                TGT: begin
                    target_q <= tgt_sum;
                    done_o   <= 1'b1;
                    state    <= UPD;
                    // A taken target that is not word aligned faults and leaves PC/rd alone.
                    if (tgt_sum[1]) begin
                        fault_o <= 1'b1;
                        pc_we_q <= 1'b0;
                    end else begin
                        taken_o <= 1'b1;
                        pc_we_q <= 1'b1;
                        if (kind_q != KIND_BRANCH) begin
                            rd_we_o   <= 1'b1;
                            rd_data_o <= link_q;
                        end
                    end
                end
                SEQ: begin
                    target_q <= alu_res_i;
                    pc_we_q  <= 1'b1;
                    done_o   <= 1'b1;
                    state    <= UPD;
                end
                UPD: begin
                    if (pc_we_q) pc_o <= target_q;
                    pc_we_q   <= 1'b0;
                    done_o    <= 1'b0;
                    fault_o   <= 1'b0;
                    taken_o   <= 1'b0;
                    rd_we_o   <= 1'b0;
                    rd_data_o <= '0;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: behavioural ALU, reference model
// feeding an expected queue, directed test-plan cases plus random requests.
module tb_branch_sequencer;

    localparam int          XLEN  = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0080;
    localparam int          EW    = 71;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [1:0]      kind;
    logic [2:0]      funct3;
    logic [XLEN-1:0] pc_in, rs1, rs2, imm;
    logic [XLEN-1:0] alu_a, alu_b, alu_res;
    logic            alu_sel, cmp_r;
    logic [2:0]      cmp_op;
    logic [XLEN-1:0] pc_out, rd_data;
    logic            rd_we, busy, done, taken, fault;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] cur_pc;
    logic [EW-1:0] exp_q[$];

    always #5 clk = ~clk;

    branch_sequencer #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .kind_i(kind), .funct3_i(funct3),
        .pc_i(pc_in), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel), .cmp_op_o(cmp_op),
        .alu_res_i(alu_res), .cmp_r_i(cmp_r),
        .pc_o(pc_out), .rd_we_o(rd_we), .rd_data_o(rd_data),
        .busy_o(busy), .done_o(done), .taken_o(taken), .fault_o(fault)
    );

    // Behavioural ALU and comparator shared by the sequencer.
    always_comb begin
        alu_res = alu_a + alu_b;
        case (cmp_op)
            3'b000:  cmp_r = (alu_a == alu_b);
            3'b001:  cmp_r = (alu_a != alu_b);
            3'b100:  cmp_r = ($signed(alu_a) <  $signed(alu_b));
            3'b101:  cmp_r = ($signed(alu_a) >= $signed(alu_b));
            3'b110:  cmp_r = (alu_a <  alu_b);
            3'b111:  cmp_r = (alu_a >= alu_b);
            default: cmp_r = 1'b0;
        endcase
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: {latency, taken, fault, rd_we, rd_data, next pc}.
    function automatic logic [EW-1:0] model(input logic [1:0] k, input logic [2:0] f3,
        input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] im, input logic [31:0] pc_now);
        logic [3:0]  lat;
        logic        tk, ft, we, cond;
        logic [31:0] rdv, np, t;
        lat = 4'd3; tk = 1'b0; ft = 1'b0; we = 1'b0; rdv = '0; np = pc_now; cond = 1'b0;
        t = '0;
        if (k == 2'b11 || (k == 2'b00 && (f3 == 3'b010 || f3 == 3'b011))) begin
            lat = 4'd1; ft = 1'b1;
        end else begin
            if (k == 2'b00) begin
                case (f3)
                    3'b000: cond = (a == b);
                    3'b001: cond = (a != b);
                    3'b100: cond = ($signed(a) <  $signed(b));
                    3'b101: cond = ($signed(a) >= $signed(b));
                    3'b110: cond = (a <  b);
                    default: cond = (a >= b);
                endcase
                t = p + im;
            end else begin
                cond = 1'b1;
                t = (k == 2'b10) ? ((a + im) & ~32'd1) : (p + im);
            end
            if (!cond) np = p + 32'd4;
            else if (t[1]) ft = 1'b1;
            else begin
                tk = 1'b1; np = t;
                if (k != 2'b00) begin we = 1'b1; rdv = p + 32'd4; end
            end
        end
        return {lat, tk, ft, we, rdv, np};
    endfunction

    // Issue one request, optionally strobe start while busy, then score the result.
    task automatic run_req(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] p,
        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im, input bit glitch);
        logic [EW-1:0] e;
        int n;
        exp_q.push_back(model(k, f3, p, a, b, im, cur_pc));
        kind = k; funct3 = f3; pc_in = p; rs1 = a; rs2 = b; imm = im; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        kind = 2'($urandom); funct3 = 3'($urandom); pc_in = $urandom;
        rs1 = $urandom; rs2 = $urandom; imm = $urandom;
        n = 1;
        while (!done && n < 10) begin
            if (glitch && n == 1) begin kind = 2'b11; start = 1'b1; end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        e = exp_q.pop_front();
        check_val("latency", 64'(n), 64'(e[70:67]));
        check_val("done", 64'(done), 64'd1);
        check_val("taken", 64'(taken), 64'(e[66]));
        check_val("fault", 64'(fault), 64'(e[65]));
        check_val("rd_we", 64'(rd_we), 64'(e[64]));
        if (e[64]) check_val("rd_data", 64'(rd_data), 64'(e[63:32]));
        check_val("upd_alu", 64'({alu_sel, cmp_op, alu_a | alu_b}), 64'd0);
        // A strobe during the UPD cycle must not be accepted.
        kind = 2'b11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("pc", 64'(pc_out), 64'(e[31:0]));
        check_val("idle_after_upd", 64'({busy, done}), 64'd0);
        cur_pc = e[31:0];
        if (glitch) begin
            n = 0;
            repeat (5) begin @(posedge clk); #1; if (done) n++; end
            check_val("no_extra_done", 64'(n), 64'd0);
        end
    endtask

    initial begin
        int n;
        logic [1:0]  rk;
        logic [2:0]  rf;
        logic [31:0] ra, rb, ri;
        rst = 1'b1; start = 1'b0; kind = '0; funct3 = '0;
        pc_in = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_pc", 64'(pc_out), 64'(RST_PC));
        check_val("reset_flags", 64'({busy, done, taken, fault, rd_we}), 64'd0);
        check_val("reset_rd_data", 64'(rd_data), 64'd0);
        check_val("reset_alu", 64'({alu_sel, cmp_op, alu_a | alu_b}), 64'd0);
        rst = 1'b0;
        cur_pc = RST_PC;
        @(posedge clk); #1;

        run_req(2'b00, 3'b000, 32'd100, 32'd5, 32'd5, 32'd40, 1'b0);                // BEQ taken
        run_req(2'b00, 3'b100, 32'd300, 32'hFFFF_FFFF, 32'd1, 32'd64, 1'b0);        // BLT true
        run_req(2'b00, 3'b110, 32'd300, 32'hFFFF_FFFF, 32'd1, 32'd64, 1'b0);        // BLTU false
        run_req(2'b10, 3'b000, 32'd200, 32'd1001, 32'd0, 32'd2, 1'b0);              // JALR
        run_req(2'b01, 3'b000, 32'd0, 32'd0, 32'd0, 32'd6, 1'b0);                   // JAL misaligned
        run_req(2'b00, 3'b010, 32'd500, 32'd1, 32'd1, 32'd8, 1'b0);                 // illegal f3
        run_req(2'b00, 3'b011, 32'd500, 32'd1, 32'd1, 32'd8, 1'b0);
        run_req(2'b11, 3'b000, 32'd500, 32'd1, 32'd1, 32'd8, 1'b0);                 // reserved kind
        run_req(2'b00, 3'b000, 32'hFFFF_FFFC, 32'd7, 32'd7, 32'd8, 1'b0);           // wrap
        run_req(2'b00, 3'b001, 32'd40, 32'd3, 32'd3, 32'd16, 1'b1);                 // BNE false, busy strobe
        run_req(2'b00, 3'b101, 32'd40, 32'h8000_0000, 32'd0, 32'd16, 1'b0);         // BGE false
        run_req(2'b00, 3'b111, 32'd40, 32'h8000_0000, 32'd0, 32'hFFFF_FFF0, 1'b0);  // BGEU true
        run_req(2'b00, 3'b000, 32'd40, 32'd9, 32'd9, 32'd6, 1'b0);                  // taken misaligned
        run_req(2'b01, 3'b000, 32'd1000, 32'd0, 32'd0, 32'hFFFF_FFF8, 1'b1);        // JAL back, busy strobe

        // Reset while in TGT, with a start strobe while busy.
        kind = 2'b01; pc_in = 32'd300; imm = 32'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; kind = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("midrst_pc", 64'(pc_out), 64'(RST_PC));
        check_val("midrst_flags", 64'({busy, done, rd_we, fault}), 64'd0);
        n = 0;
        repeat (6) begin @(posedge clk); #1; if (done || rd_we) n++; end
        check_val("midrst_no_done", 64'(n), 64'd0);
        cur_pc = RST_PC;

        for (int i = 0; i < 40; i++) begin
            rk = 2'($urandom_range(0, 3));
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? ra : $urandom;
            ri = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'd3);
            run_req(rk, rf, $urandom & ~32'd3, ra, rb, ri, (i % 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
